// File: rtl/key_matrix_encoder.sv
// key_matrix_encoder: debounced active-low key matrix to registered priority code
// with press/release event pulses, multi-key flag and latched/momentary code mode.
module key_matrix_encoder #(
    parameter int NUM_KEYS  = 8,
    parameter int CLK_DIV   = 2000,
    parameter int DEB_TICKS = 4,
    parameter int CODE_W    = 4,
    parameter int LATCH     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key,
    output logic [CODE_W-1:0]   code,
    output logic                code_valid,
    output logic                press_pulse,
    output logic                release_pulse,
    output logic                multi,
    output logic                tick
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int CW = $clog2(DEB_TICKS + 1);
    localparam int PW = $clog2(NUM_KEYS + 1);

    generate
        if ((2 ** CODE_W) < NUM_KEYS + 1 || CLK_DIV < 2 || DEB_TICKS < 1) begin : g_bad_params
            $error("key_matrix_encoder: illegal parameter combination");
        end
    endgenerate

    logic [DW-1:0]       div_cnt;
    logic [NUM_KEYS-1:0] key_m, key_s, stable, pressed;
    logic [CW-1:0]       cnt [NUM_KEYS];
    logic [CODE_W-1:0]   enc, prev;
    logic [PW-1:0]       cnt_pressed;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= div_cnt == DW'(CLK_DIV - 1);
            div_cnt <= div_cnt == DW'(CLK_DIV - 1) ? '0 : div_cnt + DW'(1);
        end
    end

    // A key's stable level only flips after DEB_TICKS consecutive disagreeing ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_m  <= '1;
            key_s  <= '1;
            stable <= '1;
            for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
        end else begin
            key_m <= key;
            key_s <= key_m;
            if (tick) begin
                for (int i = 0; i < NUM_KEYS; i++) begin
                    if (key_s[i] == stable[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == CW'(DEB_TICKS - 1)) begin
                        stable[i] <= ~stable[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

    assign pressed = ~stable;

    // Scanning downward leaves the lowest pressed index as the winner.
    always_comb begin
        enc         = '0;
        cnt_pressed = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pressed[i]) begin
                enc         = CODE_W'(i + 1);
                cnt_pressed = cnt_pressed + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            code          <= '0;
            code_valid    <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            multi         <= 1'b0;
            prev          <= '0;
        end else begin
            code          <= (LATCH == 0 || enc != '0) ? enc : code;
            code_valid    <= enc != '0;
            multi         <= cnt_pressed > PW'(1);
            press_pulse   <= enc != '0 && enc != prev;
            release_pulse <= enc == '0 && prev != '0;
            prev          <= enc;
        end
    end
endmodule

// File: doc/key_matrix_encoder.md
Name: key_matrix_encoder

Overview:
Parametrised successor to the board push-button/joystick decoder. It samples NUM_KEYS active-low buttons on a prescaled tick and debounces each key independently with a counter. A priority encoder turns the debounced keys into a registered key code for LEDs or downstream logic. It adds what the fixed 8-key decoder lacks: clean synchronous reset, input synchronisers, real debounce, press/release event pulses, multi-key detection and a selectable latched/momentary mode.

Parameters:
NUM_KEYS, 8, number of active-low key inputs (1..32)
CLK_DIV, 2000, clk cycles per sample tick (>=2)
DEB_TICKS, 4, consecutive ticks a key must differ from its stable value before it flips (>=1)
CODE_W, 4, width of code output; must satisfy 2^CODE_W >= NUM_KEYS+1
LATCH, 1, 1 = code holds last pressed key after release; 0 = code returns to 0 on release

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
key  input  NUM_KEYS  raw buttons, asynchronous, active-low (0 = pressed)
code  output  CODE_W  registered key code: index+1 of the winning key, 0 = none
code_valid  output  1  high while at least one debounced key is pressed
press_pulse  output  1  one-clk pulse when the encoded code changes to a new nonzero value
release_pulse  output  1  one-clk pulse when the encoded code changes from nonzero to 0
multi  output  1  high while more than one debounced key is pressed
tick  output  1  one-clk sample strobe, exported for test and for chaining

Behaviour:
- One clock domain (clk). reset is synchronous and active-high, sampled only on the rising edge of clk; it overrides all other activity, including mid-debounce.
- Reset values: code=0, code_valid=0, press_pulse=0, release_pulse=0, multi=0, tick=0; prescaler=0; synchroniser flops and stable vector all 1 (released); debounce counters 0; previous-code register 0.
- Prescaler: counts 0..CLK_DIV-1. tick is registered and is high for the one cycle after the count equals CLK_DIV-1; the count then wraps to 0. The first tick follows CLK_DIV cycles after reset deasserts.
- Synchroniser: 2-flop synchroniser on each key bit, giving key_s.
- Debounce, per key i, evaluated only on tick:
  - If key_s[i]==stable[i], cnt[i] is cleared to 0.
  - Otherwise cnt[i] increments. When the increment would reach DEB_TICKS, stable[i] toggles and cnt[i] clears in that same cycle.
  - A glitch shorter than DEB_TICKS ticks never changes stable.
  - cnt width is clog2(DEB_TICKS+1).
- pressed = ~stable. Encoder is combinational from pressed:
  - enc = (lowest index i with pressed[i]) + 1, or 0 if none.
  - cnt_pressed = popcount(pressed).
- Output stage, registered every clk:
  - code_valid <= (enc!=0); multi <= (cnt_pressed>1).
  - LATCH=0: code <= enc. LATCH=1: code <= enc when enc!=0, otherwise code holds.
  - press_pulse <= (enc!=0 && enc!=prev); release_pulse <= (enc==0 && prev!=0); prev <= enc.
  - Pulses last exactly one clk.
  - A change between two nonzero codes (e.g. releasing the winning key while another is held) gives press_pulse only.
- Latency: a stable level change on key reaches stable after 2 clk (sync), then on the DEB_TICKS-th qualifying tick. Outputs update 1 clk after stable.
- Simultaneous presses debouncing on the same tick give one press_pulse, with code = lowest index, and multi=1.
- Elaboration asserts an error if 2^CODE_W < NUM_KEYS+1, CLK_DIV<2 or DEB_TICKS<1.

Test Plan:
- Reset/idle (CLK_DIV=4, DEB_TICKS=3, NUM_KEYS=8): hold reset 5 clk, key=8'hFF -> all outputs 0. tick pulses every 4 clk after release.
- Clean press key[2] (key=8'hFB) held 20 clk -> stable flips on the 3rd tick. Next clk: code=3, code_valid=1, press_pulse=1 for exactly 1 clk, multi=0.
- Glitch: key=8'hFB for 2 ticks, then 8'hFF -> no output change, no pulses.
- Release with LATCH=1 after the press above -> release_pulse 1 clk, code_valid=0, code stays 3. With LATCH=0 -> code=0.
- Multi-key: key[1] and key[5] pressed together (8'hDD) -> code=2, multi=1, one press_pulse. Then release key[1] -> code=6, press_pulse=1, no release_pulse, multi=0.
- Reset mid-debounce: assert reset after 2 qualifying ticks of a press -> all outputs 0 and counters cleared. After reset, with the key still held, the full 3 ticks are needed before press_pulse.
